// File: rtl/wakeup_broadcast_arbiter.sv
// Result wakeup arbiter: per-FU FIFOs whose heads are granted round-robin onto
// NUM_SLOTS registered broadcast buses (tag + value) each cycle.
module wakeup_broadcast_arbiter #(
  parameter int NUM_REQ   = 6,
  parameter int NUM_SLOTS = 4,
  parameter int DEPTH     = 2,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic [TAG_W*NUM_REQ-1:0]      in_tag,
  input  logic [DATA_W*NUM_REQ-1:0]     in_value,
  output logic [NUM_SLOTS-1:0]          wakeup_active,
  output logic [TAG_W*NUM_SLOTS-1:0]    wakeup_tag,
  output logic [DATA_W*NUM_SLOTS-1:0]   wakeup_value,
  output logic [$clog2(NUM_REQ*DEPTH+1)-1:0] pending_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PC_W  = $clog2(NUM_REQ * DEPTH + 1);

  logic [TAG_W-1:0]  tag_mem   [NUM_REQ][DEPTH];
  logic [DATA_W-1:0] value_mem [NUM_REQ][DEPTH];
  logic [PTR_W-1:0]  head      [NUM_REQ];
  logic [CNT_W-1:0]  count     [NUM_REQ];
  logic [CNT_W-1:0]  count_nxt [NUM_REQ];
  logic [RR_W-1:0]   rr_ptr;

  logic [NUM_REQ-1:0]   store_p0;
  logic [NUM_REQ-1:0]   grant_p0;
  logic [NUM_SLOTS-1:0] slot_vld_p0;
  logic [RR_W-1:0]      slot_src_p0 [NUM_SLOTS];
  logic [TAG_W-1:0]     slot_tag_p0 [NUM_SLOTS];
  logic [DATA_W-1:0]    slot_val_p0 [NUM_SLOTS];
  logic [RR_W-1:0]      last_idx_p0;
  logic                 any_grant_p0;
  logic [PC_W-1:0]      pend_nxt;
  int                   idx;
  int                   n_grant;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int off);
    return PTR_W'((int'(base) + off) % DEPTH);
  endfunction

  // p0: acceptance, round-robin arbitration over pre-edge heads, next counts
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      in_ready[i] = (int'(count[i]) < DEPTH);
      // tag 0 is the never-woken register, so it is accepted but dropped
      store_p0[i] = in_valid[i] && in_ready[i] && (in_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  always_comb begin
    grant_p0     = '0;
    slot_vld_p0  = '0;
    last_idx_p0  = '0;
    any_grant_p0 = 1'b0;
    n_grant      = 0;
    idx          = 0;
    for (int s = 0; s < NUM_SLOTS; s++) slot_src_p0[s] = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (count[idx] != '0 && n_grant < NUM_SLOTS) begin
        grant_p0[idx]        = 1'b1;
        slot_vld_p0[n_grant] = 1'b1;
        slot_src_p0[n_grant] = RR_W'(idx);
        last_idx_p0          = RR_W'(idx);
        any_grant_p0         = 1'b1;
        n_grant              = n_grant + 1;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      slot_tag_p0[s] = '0;
      slot_val_p0[s] = '0;
      if (slot_vld_p0[s]) begin
        slot_tag_p0[s] = tag_mem[slot_src_p0[s]][head[slot_src_p0[s]]];
        slot_val_p0[s] = value_mem[slot_src_p0[s]][head[slot_src_p0[s]]];
      end
    end
  end

  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      count_nxt[i] = count[i] + CNT_W'(store_p0[i]) - CNT_W'(grant_p0[i]);
      pend_nxt     = pend_nxt + PC_W'(count_nxt[i]);
    end
  end

  // p1: FIFO state and registered broadcast slots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        head[i]  <= '0;
        count[i] <= '0;
      end
      rr_ptr        <= '0;
      wakeup_active <= '0;
      wakeup_tag    <= '0;
      wakeup_value  <= '0;
      pending_count <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        head[i]  <= '0;
        count[i] <= '0;
      end
      rr_ptr        <= '0;
      wakeup_active <= '0;
      wakeup_tag    <= '0;
      wakeup_value  <= '0;
      pending_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count[i] <= count_nxt[i];
        if (grant_p0[i]) head[i] <= ptr_add(head[i], 1);
      end
      if (any_grant_p0) rr_ptr <= RR_W'((int'(last_idx_p0) + 1) % NUM_REQ);
      wakeup_active <= slot_vld_p0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        wakeup_tag[s*TAG_W +: TAG_W]    <= slot_tag_p0[s];
        wakeup_value[s*DATA_W +: DATA_W] <= slot_val_p0[s];
      end
      pending_count <= pend_nxt;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by count/head only
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (store_p0[i]) begin
        tag_mem[i][ptr_add(head[i], int'(count[i]))]   <= in_tag[i*TAG_W +: TAG_W];
        value_mem[i][ptr_add(head[i], int'(count[i]))] <= in_value[i*DATA_W +: DATA_W];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      for (int a = 0; a < NUM_SLOTS; a++)
        for (int b = a + 1; b < NUM_SLOTS; b++)
          if (slot_vld_p0[a] && slot_vld_p0[b] && slot_tag_p0[a] == slot_tag_p0[b])
            $fatal(1, "wakeup_broadcast_arbiter: duplicate granted tag %0d", slot_tag_p0[a]);
      for (int i = 0; i < NUM_REQ; i++)
        if (store_p0[i])
          for (int j = 0; j < NUM_REQ; j++)
            for (int d = 0; d < DEPTH; d++)
              if (d < int'(count[j]) &&
                  tag_mem[j][ptr_add(head[j], d)] == in_tag[i*TAG_W +: TAG_W])
                $fatal(1, "wakeup_broadcast_arbiter: accepted tag %0d already held",
                       in_tag[i*TAG_W +: TAG_W]);
    end
  end
`endif

endmodule
